// File: rtl/gray_decode_stream_if.sv
// Stream bundle for the Gray decoder: Gray words in, binary values plus step flag out.
// The master drives the input words and the output-side ready; the slave is the decoder.
interface gray_decode_stream_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bin;
    logic             out_step_err;

    modport master (
        output in_valid,
        output in_gray,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bin,
        input  out_step_err
    );

    modport slave (
        input  in_valid,
        input  in_gray,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bin,
        output out_step_err
    );
endinterface

// File: rtl/gray_decode_stream.sv
// Two-stage streaming Gray-to-binary decoder with step checking and a saturating
// count of flagged words handed downstream.
module gray_decode_stream #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    gray_decode_stream_if.slave        bus,
    output logic [CNT_WIDTH-1:0]       err_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_gray_q,  s1_gray_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     s2_bin_q,   s2_bin_d;
    logic                 s2_err_q,   s2_err_d;
    logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;
    logic                 have_prev_q, have_prev_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic                 s2_load_s;
    logic                 in_ready_s;
    logic                 in_xfer_s;
    logic                 hand_off_s;
    logic [WIDTH-1:0]     dec_bin_s;
    logic [WIDTH-1:0]     delta_s;
    logic                 step_bad_s;

    // Handshake decisions; out_ready reaches in_ready through exactly one gate level.
    always_comb begin
        s2_load_s  = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_ready_s = !s1_valid_q || s2_load_s;
        in_xfer_s  = bus.in_valid && in_ready_s;
        hand_off_s = s2_valid_q && bus.out_ready;
    end

    // Decode of the stage-1 word and its distance from the last decoded value.
    always_comb begin
        dec_bin_s  = gray_to_bin(s1_gray_q);
        delta_s    = dec_bin_s - prev_bin_q;
        step_bad_s = have_prev_q && (delta_s != {WIDTH{1'b0}}) && (delta_s != STEP_ONE);
    end

    // Stage 1 next state: capture on transfer, empty when drained into stage 2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_gray_d  = s1_gray_q;
        if (in_xfer_s) begin
            s1_valid_d = 1'b1;
            s1_gray_d  = bus.in_gray;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state; the step history follows every load, not every hand-off.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_bin_d    = s2_bin_q;
        s2_err_d    = s2_err_q;
        prev_bin_d  = prev_bin_q;
        have_prev_d = have_prev_q;
        if (s2_load_s) begin
            s2_valid_d  = 1'b1;
            s2_bin_d    = dec_bin_s;
            s2_err_d    = step_bad_s;
            prev_bin_d  = dec_bin_s;
            have_prev_d = 1'b1;
        end else if (hand_off_s) begin
            s2_valid_d  = 1'b0;
        end else begin
            s2_valid_d  = s2_valid_q;
        end
    end

    // Error counter counts flagged words only once they leave, and sticks at full scale.
    always_comb begin
        err_count_d = err_count_q;
        if (hand_off_s && s2_err_q && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_ONE;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Pipeline state register; reset discards in-flight words and the step history.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_gray_q   <= {WIDTH{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_bin_q    <= {WIDTH{1'b0}};
            s2_err_q    <= 1'b0;
            prev_bin_q  <= {WIDTH{1'b0}};
            have_prev_q <= 1'b0;
            err_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_gray_q   <= s1_gray_d;
            s2_valid_q  <= s2_valid_d;
            s2_bin_q    <= s2_bin_d;
            s2_err_q    <= s2_err_d;
            prev_bin_q  <= prev_bin_d;
            have_prev_q <= have_prev_d;
            err_count_q <= err_count_d;
        end
    end

    // Outputs come straight from stage-2 flops; only in_ready is combinational.
    always_comb begin
        bus.in_ready     = in_ready_s;
        bus.out_valid    = s2_valid_q;
        bus.out_bin      = s2_bin_q;
        bus.out_step_err = s2_err_q;
        err_count        = err_count_q;
    end

endmodule

// File: tb/tb_gray_decode_stream.sv
// Scoreboard bench for gray_decode_stream: words are encoded here from binary values,
// expected binary/step-flag pairs are queued on accept and checked on hand-off.
module tb_gray_decode_stream;

    logic       clk;
    logic       rst;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    gray_decode_stream_if #(.WIDTH(4)) bus ();
    gray_decode_stream_if #(.WIDTH(4)) bus2 ();

    gray_decode_stream #(.WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .err_count (err_count)
    );

    gray_decode_stream #(.WIDTH(4), .CNT_WIDTH(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2.slave),
        .err_count (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    int         stim_q[$];
    logic [3:0] sb_bin[$];
    logic       sb_err[$];
    int         prev_b    = 0;
    bit         have_prev = 1'b0;
    int         exp_cnt   = 0;
    int         first_acc_cyc, first_out_cyc, last_out_cyc, n_out;

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    // Push the expected result of word b onto the scoreboard, tracking step history.
    task automatic expect_word(input int b);
        int dl;
        dl = (b - prev_b + 16) % 16;
        sb_bin.push_back(b[3:0]);
        sb_err.push_back(have_prev && (dl > 1));
        prev_b    = b;
        have_prev = 1'b1;
    endtask

    // Feed stim_q through the main DUT, stalling out_ready in [stall_start, stall_start+stall_len).
    task automatic run_stream(input int stall_start, input int stall_len);
        int         idx = 0;
        int         cyc = 0;
        bit         held_v = 1'b0;
        logic [3:0] held_bin = 4'd0;
        logic       held_err = 1'b0;
        logic [3:0] got_bin;
        logic       got_err;
        first_acc_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; n_out = 0;
        while ((idx < stim_q.size() || sb_bin.size() != 0) && cyc < 300) begin
            @(negedge clk);
            bus.in_valid  = (idx < stim_q.size());
            bus.in_gray   = (idx < stim_q.size()) ? to_gray(stim_q[idx]) : 4'd0;
            bus.out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            vectors++;
            if (err_count !== exp_cnt[7:0]) begin
                miscompares++;
                $display("FAIL err_count cyc=%0d got=%0d exp=%0d", cyc, err_count, exp_cnt);
            end
            if (!bus.out_ready && sb_bin.size() == 2) begin
                vectors++;
                if (bus.in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL in_ready_full cyc=%0d got=%b exp=0", cyc, bus.in_ready);
                end
            end
            if (held_v) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_bin !== held_bin || bus.out_step_err !== held_err) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc,
                             bus.out_valid, bus.out_bin, bus.out_step_err, held_bin, held_err);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                vectors++;
                if (sb_bin.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output cyc=%0d got=%h exp=none", cyc, bus.out_bin);
                end else begin
                    got_bin = sb_bin.pop_front();
                    got_err = sb_err.pop_front();
                    if (bus.out_bin !== got_bin || bus.out_step_err !== got_err) begin
                        miscompares++;
                        $display("FAIL output cyc=%0d got=%h/%b exp=%h/%b", cyc,
                                 bus.out_bin, bus.out_step_err, got_bin, got_err);
                    end
                    if (got_err && exp_cnt < 255) exp_cnt++;
                end
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                n_out++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                expect_word(stim_q[idx]);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                idx++;
            end
            held_v   = (bus.out_valid === 1'b1) && !bus.out_ready;
            held_bin = bus.out_bin;
            held_err = bus.out_step_err;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        vectors++;
        if (cyc >= 300) begin
            miscompares++;
            $display("FAIL stream_timeout got=%0d pending exp=0", sb_bin.size());
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || err_count !== exp_cnt[7:0]) begin
            miscompares++;
            $display("FAIL drain_idle got=%b/%0d exp=0/%0d", bus.out_valid, err_count, exp_cnt);
        end
        stim_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || err_count !== 8'd0 ||
            bus.out_bin !== 4'd0 || bus.out_step_err !== 1'b0 || err_count2 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state got=%b/%b/%0d/%h/%b exp=0/1/0/0/0",
                     bus.out_valid, bus.in_ready, err_count, bus.out_bin, bus.out_step_err);
        end
    endtask

    task automatic test_decode_sweep();
        for (int i = 0; i < 16; i++) stim_q.push_back(i);
        run_stream(1000, 0);
        vectors++;
        if (first_out_cyc - first_acc_cyc !== 2 || last_out_cyc - first_out_cyc !== 15 || n_out !== 16) begin
            miscompares++;
            $display("FAIL sweep_timing got=lat%0d/span%0d/n%0d exp=lat2/span15/n16",
                     first_out_cyc - first_acc_cyc, last_out_cyc - first_out_cyc, n_out);
        end
    endtask

    task automatic test_wrap_hold();
        stim_q = '{15, 0, 0, 1};
        run_stream(1000, 0);
    endtask

    task automatic test_illegal_step();
        stim_q = '{1, 4};
        run_stream(1000, 0);
        vectors++;
        if (err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL illegal_step_count got=%0d exp=1", err_count);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        for (int i = 4; i < 12; i++) stim_q.push_back(i);
        run_stream(4, 5);
        vectors++;
        if (n_out !== 8) begin
            miscompares++;
            $display("FAIL backpressure_count got=%0d exp=8", n_out);
        end
    endtask

    task automatic test_reset_mid_stream();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_gray = to_gray(9); bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_gray = to_gray(10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pipe_full got=%b/%b exp=0/1", bus.in_ready, bus.out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || err_count !== 8'd0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/1", bus.out_valid, err_count, bus.in_ready);
        end
        sb_bin.delete(); sb_err.delete();
        have_prev = 1'b0; prev_b = 0; exp_cnt = 0;
        bus.out_ready = 1'b1;
        stim_q = '{4};
        run_stream(1000, 0);
    endtask

    task automatic test_saturation();
        logic [3:0] q_bin[$];
        logic       q_err[$];
        logic [3:0] eb;
        logic       ee;
        int         p2 = 0;
        bit         h2 = 1'b0;
        int         exp2 = 0;
        int         k = 0;
        int         cyc = 0;
        int         b;
        while ((k < 10 || q_bin.size() != 0) && cyc < 100) begin
            @(negedge clk);
            bus2.in_valid  = (k < 10);
            bus2.in_gray   = (k % 2 == 0) ? 4'b0000 : 4'b0110;
            bus2.out_ready = 1'b1;
            #1;
            vectors++;
            if (err_count2 !== exp2[1:0]) begin
                miscompares++;
                $display("FAIL sat_count cyc=%0d got=%0d exp=%0d", cyc, err_count2, exp2);
            end
            if (bus2.out_valid === 1'b1 && q_bin.size() != 0) begin
                eb = q_bin.pop_front();
                ee = q_err.pop_front();
                vectors++;
                if (bus2.out_bin !== eb || bus2.out_step_err !== ee) begin
                    miscompares++;
                    $display("FAIL sat_output cyc=%0d got=%h/%b exp=%h/%b", cyc,
                             bus2.out_bin, bus2.out_step_err, eb, ee);
                end
                if (ee && exp2 < 3) exp2++;
            end
            if (bus2.in_valid && bus2.in_ready === 1'b1) begin
                b = (k % 2 == 0) ? 0 : 4;
                q_bin.push_back(b[3:0]);
                q_err.push_back(h2 && (((b - p2 + 16) % 16) > 1));
                p2 = b; h2 = 1'b1;
                k++;
            end
            cyc++;
        end
        bus2.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (err_count2 !== 2'd3 || cyc >= 100) begin
            miscompares++;
            $display("FAIL sat_final got=%0d exp=3 (cycles %0d)", err_count2, cyc);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_gray = 4'd0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_gray = 4'd0; bus2.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_decode_sweep();
        test_wrap_hold();
        test_illegal_step();
        test_back_to_back_backpressure();
        test_reset_mid_stream();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_decode_stream.md
Name: gray_decode_stream

Overview:
- Streaming Gray-to-binary decoder for the receive side of Gray-coded keys and pointers, e.g. counters crossing into this domain or keys produced by the Gray-encoding mux.
- Accepts one Gray word per valid/ready handshake and emits its binary value two cycles later.
- Flags any transition that is not a single forward step or a hold, and keeps a saturating error count.

Parameters:
- WIDTH, 4, bit width of the Gray input and binary output.
- CNT_WIDTH, 8, width of the saturating step-error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_gray holds a valid Gray word.
- in_ready  output  1  block can accept a word this cycle.
- in_gray  input  WIDTH  Gray-coded word.
- out_valid  output  1  out_bin and out_step_err are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_bin  output  WIDTH  decoded binary value.
- out_step_err  output  1  this word is not prev or prev+1 (mod 2^WIDTH).
- err_count  output  CNT_WIDTH  number of flagged words handed off, saturating.

Behaviour:
- Decode rule: bin[WIDTH-1] = g[WIDTH-1]; bin[k] = bin[k+1] ^ g[k] for k = WIDTH-2 down to 0. This is the exact inverse of g = b ^ (b >> 1).
- Stage 1 holds s1_valid and s1_gray (registered raw input).
- Stage 2 holds s2_valid, s2_bin and s2_err, plus prev_bin and have_prev.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_load (combinational; no dependence on in_valid)
  - Input transfer: in_valid && in_ready; s1 captures in_gray and sets s1_valid.
  - If s1 empties with no new transfer, s1_valid clears.
  - On s2_load: s2_bin = decode(s1_gray); s2_valid = 1.
  - If s2 is handed off (out_valid && out_ready) with no s2_load, s2_valid clears.
- Step check at s2_load, computed on the decoded value d:
  - delta = (d - prev_bin) mod 2^WIDTH
  - s2_err = have_prev && (delta != 0) && (delta != 1)
  - Then prev_bin = d and have_prev = 1.
  - The first word after reset is never flagged.
  - Wrap (2^WIDTH-1 to 0) is a legal step.
- err_count increments by 1 when a word with s2_err=1 is handed off (out_valid && out_ready). It holds at 2^CNT_WIDTH-1 and never wraps.
- Latency: accept in cycle N gives out_valid in cycle N+2 when there is no backpressure. Throughput is 1 word/cycle.
- Backpressure: while out_valid && !out_ready, out_bin and out_step_err are held stable. Stage 1 holds, and in_ready drops once s1 is full.
- No combinational path from in_valid or in_gray to outputs. out_ready reaches in_ready combinationally, one level.
- Simultaneous hand-off and load: s2 is replaced in the same cycle and out_valid stays 1.
- Outputs: out_valid, out_bin, out_step_err, err_count = 0. in_ready = 1.
- Reset: s1_valid, s2_valid, s1_gray, s2_bin, s2_err, prev_bin, have_prev and err_count all clear.
- Reset mid-operation: in-flight words are discarded, not emitted, and the step history is forgotten.
- Reset dominates all simultaneous handshakes.

Test Plan:
- Decode sweep, WIDTH=4, out_ready=1: feed Gray of 0..15 (0000, 0001, 0011, 0010, ..., 1000) back-to-back. Required: out_bin = 0..15 on consecutive cycles, the first appearing 2 cycles after the first accept, out_step_err=0 throughout, err_count=0.
- Wrap and hold: feed 1000 (15), 0000 (0), 0000 (0), 0001 (1). Required: out_bin 15, 0, 0, 1, all with out_step_err=0.
- Illegal step: feed 0001 (1) then 0110 (4). Required: second output out_bin=0100 with out_step_err=1, and err_count becomes 1 in the cycle after that word's hand-off.
- Backpressure: stream 8 words and hold out_ready=0 for 5 cycles mid-stream. Required:
  - out_bin is stable while stalled.
  - in_ready=0 once s1 is full.
  - No word is lost or duplicated; the output order matches the input order.
- Reset mid-stream: rst=1 for 1 cycle while s1 and s2 are full. Required:
  - The next cycle shows out_valid=0, err_count=0, in_ready=1.
  - The next input 0110 (4) then emits out_bin=4 with out_step_err=0 (no history).
- Saturation, CNT_WIDTH=2: alternate 0000 and 0110 for 10 words, all handed off. Required: err_count reaches 3 and stays at 3.
